param_core: RTL and testbench
=============================

# param_core

Parametrised single-issue accumulator-free core: fetches from an instruction memory and executes a small register-register ISA. Load/store goes to a data memory. Both memories use req/ack handshakes, so variable-latency memories and arbiters can sit in front of them. Data width, register count, PC width and address width are parameters. The block is the building unit for multi-core tops: the core halts cleanly and flags illegal opcodes.

## Interface
- `DATA_W`, 32, datapath, register and memory word width
- `NREG`, 16, register count; power of two; `RW = log2(NREG)`
- `PC_W`, 6, program counter / instruction address width
- `AR_W`, 12, data address and immediate width; must satisfy `AR_W >= 2*RW`, `AR_W >= PC_W`
- Derived: instruction width `IW = 4 + RW + AR_W` (20 at defaults)

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `imem_req` out 1: fetch request.
- `imem_addr` out PC_W: fetch address, equal to PC.
- `imem_ack` in 1: fetch data valid this cycle.
- `imem_data` in IW: instruction word.
- `dmem_req` out 1: data access request.
- `dmem_we` out 1: 1 = store, 0 = load; valid with `dmem_req`.
- `dmem_addr` out AR_W: data address.
- `dmem_wdata` out DATA_W: store data.
- `dmem_ack` in 1: access complete; load data valid.
- `dmem_rdata` in DATA_W: load data.
- `End` out 1: core halted.
- `err` out 1: halted because of an illegal opcode.

## Operation
- Fields:
  - op = `IR[IW-1:IW-4]`
  - rd = next RW bits
  - imm = `IR[AR_W-1:0]`
  - ra = `imm[AR_W-1:AR_W-RW]`
  - rb = `imm[AR_W-RW-1:AR_W-2RW]`
  - target = `imm[PC_W-1:0]`
- Opcodes:
  - 0 NOP
  - 1 LDI: rd ← zero-extended imm
  - 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR: rd ← ra op rb
  - 7 SHL: rd ← ra<<1
  - 8 LD: rd ← mem[ra[AR_W-1:0]]
  - 9 ST: mem[ra[AR_W-1:0]] ← rd
  - 10 JMP: PC ← target
  - 11 JZ: PC ← target if Z
  - 12 MOV: rd ← ra
  - 13 HALT
  - 14 MUL (see Configuration)
  - 15 illegal
- Arithmetic is modulo 2^DATA_W; carries are discarded. SUB is ra − rb, two's complement.
- Z flag is updated only by opcodes 2–7 (and 14 when enabled): Z = (result == 0). All other opcodes leave Z unchanged.
- All NREG registers are writable; there is no hardwired zero register.
- FSM states: FETCH, EXEC, MEM, HALT.
  - FETCH: `imem_req`=1. On `imem_ack`, IR ← `imem_data`, PC ← PC+1 (wraps mod 2^PC_W), go to EXEC.
  - EXEC:
    - ALU/LDI/MOV: write rd, go to FETCH.
    - JMP/taken JZ: PC ← target, go to FETCH.
    - NOP/untaken JZ: go to FETCH.
    - LD/ST: latch address (and store data), go to MEM.
    - HALT: go to HALT.
    - Illegal: err ← 1, go to HALT.
  - MEM: `dmem_req`=1, with address, `dmem_we` and `dmem_wdata` stable until ack. On `dmem_ack`: LD writes rd ← `dmem_rdata`; then go to FETCH.
  - HALT: `End`=1; stays until `rst`.
- `imem_ack` outside FETCH and `dmem_ack` outside MEM are ignored.

## Timing
- Reset values:
  - PC=0, all registers=0, Z=0, IR=0
  - state=FETCH
  - `imem_req`=1 on the first cycle after reset
  - `dmem_req`=0, `dmem_we`=0, `dmem_addr`=0, `dmem_wdata`=0
  - `End`=0, `err`=0
- `imem_req`, `dmem_req` and `End` are decoded from registered state only; there is no combinational path from ack to req.
- With zero-wait memories (ack in the same cycle as req):
  - ALU/LDI/MOV/jump/NOP: 2 cycles.
  - LD/ST: 3 cycles.
  - Each wait cycle adds 1.
- A register write and the Z update take effect at the end of EXEC (or MEM for LD). The next instruction's EXEC sees the new value, so no hazards are possible.
- `rst` asserted mid-FETCH or mid-MEM: the outstanding request is abandoned. `req` is 0 or re-targeted to PC=0 next cycle, and no register write occurs.
- `rst` while in HALT returns the core to FETCH at PC=0 with `End`=0 and `err`=0.
- A JMP to the current PC loops forever; this is legal.

## Configuration
- `PARAM_CORE_MUL_EN` defined: opcode 14 is MUL, rd ← low DATA_W bits of ra*rb, and updates Z. Latency is the same as ADD.
- `PARAM_CORE_MUL_EN` undefined: opcode 14 is illegal and behaves exactly like 15 (`err`=1, halt). No multiplier is synthesised.

## Test plan
- Reset, zero-wait memory, program LDI r1,5; LDI r2,3; SUB r3,r1,r2; HALT → r3=2, Z=0, `End`=1 on cycle 8, `err`=0.
- LDI r1,7; SUB r2,r1,r1; JZ 5; LDI r4,1; (addr 5) HALT → Z=1, jump taken, r4 stays 0.
- ST then LD with `dmem_ack` delayed 3 cycles → `dmem_req`, `dmem_addr` and `dmem_wdata` held stable for 4 cycles. The loaded value equals the stored value (0xDEADBEEF at addr 0x00A).
- PC wrap: NOPs filling all 64 locations → `imem_addr` sequence 63 → 0, no `End`.
- Opcode 14 with r1=0x10000, r2=0x10000: with MUL enabled → rd=0, Z=1. Without it → `err`=1, `End`=1.
- `rst` asserted in the middle of a stalled LD → next cycle `dmem_req`=0, `imem_addr`=0, rd unchanged. The core then re-executes from 0.

Source files
------------

// File: rtl/param_core_if.sv
// Instruction- and data-memory req/ack buses of param_core.
// The core sits on the master side; memories or arbiters sit on the slave side.
interface param_core_if #(
  parameter int DATA_W = 32,
  parameter int NREG   = 16,
  parameter int PC_W   = 6,
  parameter int AR_W   = 12
);
  localparam int RW = $clog2(NREG);
  localparam int IW = 4 + RW + AR_W;

  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_ack;
  logic [IW-1:0]     imem_data;

  logic              dmem_req;
  logic              dmem_we;
  logic [AR_W-1:0]   dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  imem_ack, imem_data, dmem_ack, dmem_rdata
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output imem_ack, imem_data, dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/param_core.sv
// Multi-cycle register-register core with req/ack instruction and data memories.
// Define PARAM_CORE_MUL_EN to make opcode 14 a multiply; otherwise it is illegal.
module param_core #(
  parameter int DATA_W = 32,
  parameter int NREG   = 16,
  parameter int PC_W   = 6,
  parameter int AR_W   = 12
) (
  input  logic           clk,
  input  logic           rst,
  param_core_if.master   bus,
  output logic           End,
  output logic           err
);
  localparam int RW = $clog2(NREG);
  localparam int IW = 4 + RW + AR_W;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_LDI  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_SHL  = 4'd7;
  localparam logic [3:0] OP_LD   = 4'd8;
  localparam logic [3:0] OP_ST   = 4'd9;
  localparam logic [3:0] OP_JMP  = 4'd10;
  localparam logic [3:0] OP_JZ   = 4'd11;
  localparam logic [3:0] OP_MOV  = 4'd12;
  localparam logic [3:0] OP_HALT = 4'd13;
  localparam logic [3:0] OP_MUL  = 4'd14;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

  state_t            r_state;
  logic [PC_W-1:0]   r_pc;
  logic [IW-1:0]     r_ir;
  logic              r_z;
  logic [DATA_W-1:0] r_regs [NREG];
  logic              r_imem_req;
  logic              r_dmem_req;
  logic              r_dmem_we;
  logic [AR_W-1:0]   r_dmem_addr;
  logic [DATA_W-1:0] r_dmem_wdata;
  logic              r_end;
  logic              r_err;

  logic [3:0]        w_op;
  logic [RW-1:0]     w_rd;
  logic [AR_W-1:0]   w_imm;
  logic [RW-1:0]     w_ra;
  logic [RW-1:0]     w_rb;
  logic [PC_W-1:0]   w_tgt;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic [DATA_W-1:0] w_d;
  logic [DATA_W-1:0] w_alu;

  function automatic logic is_alu(input logic [3:0] op);
    logic res;
    res = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL: res = 1'b1;
`ifdef PARAM_CORE_MUL_EN
      OP_MUL: res = 1'b1;
`endif
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic logic [DATA_W-1:0] alu(input logic [3:0] op,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] res;
    res = '0;
    case (op)
      OP_ADD: res = a + b;
      OP_SUB: res = a - b;
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_SHL: res = {a[DATA_W-2:0], 1'b0};
`ifdef PARAM_CORE_MUL_EN
      OP_MUL: res = a * b;
`endif
      default: res = '0;
    endcase
    return res;
  endfunction

  assign w_op  = r_ir[IW-1 -: 4];
  assign w_rd  = r_ir[AR_W +: RW];
  assign w_imm = r_ir[AR_W-1:0];
  assign w_ra  = w_imm[AR_W-1 -: RW];
  assign w_rb  = w_imm[AR_W-RW-1 -: RW];
  assign w_tgt = w_imm[PC_W-1:0];
  assign w_a   = r_regs[w_ra];
  assign w_b   = r_regs[w_rb];
  assign w_d   = r_regs[w_rd];
  assign w_alu = alu(w_op, w_a, w_b);

  // Bus outputs come straight from registers: no ack-to-req combinational path.
  assign bus.imem_req   = r_imem_req;
  assign bus.imem_addr  = r_pc;
  assign bus.dmem_req   = r_dmem_req;
  assign bus.dmem_we    = r_dmem_we;
  assign bus.dmem_addr  = r_dmem_addr;
  assign bus.dmem_wdata = r_dmem_wdata;
  assign End            = r_end;
  assign err            = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_FETCH;
      r_pc         <= '0;
      r_ir         <= '0;
      r_z          <= 1'b0;
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      r_imem_req   <= 1'b1;
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
      r_end        <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (bus.imem_ack) begin
            r_ir       <= bus.imem_data;
            r_pc       <= r_pc + PC_W'(1);
            r_imem_req <= 1'b0;
            r_state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_state    <= S_FETCH;
          r_imem_req <= 1'b1;
          if (is_alu(w_op)) begin
            r_regs[w_rd] <= w_alu;
            r_z          <= (w_alu == '0);
          end else begin
            case (w_op)
              OP_NOP: ;
              OP_LDI: r_regs[w_rd] <= DATA_W'(w_imm);
              OP_MOV: r_regs[w_rd] <= w_a;
              OP_JMP: r_pc <= w_tgt;
              OP_JZ:  if (r_z) r_pc <= w_tgt;
              OP_LD, OP_ST: begin
                r_dmem_addr  <= AR_W'(w_a);
                r_dmem_we    <= (w_op == OP_ST);
                r_dmem_wdata <= w_d;
                r_dmem_req   <= 1'b1;
                r_imem_req   <= 1'b0;
                r_state      <= S_MEM;
              end
              OP_HALT: begin
                r_end      <= 1'b1;
                r_imem_req <= 1'b0;
                r_state    <= S_HALT;
              end
              default: begin
                r_err      <= 1'b1;
                r_end      <= 1'b1;
                r_imem_req <= 1'b0;
                r_state    <= S_HALT;
              end
            endcase
          end
        end
        S_MEM: begin
          if (bus.dmem_ack) begin
            if (!r_dmem_we) r_regs[w_rd] <= bus.dmem_rdata;
            r_dmem_req <= 1'b0;
            r_imem_req <= 1'b1;
            r_state    <= S_FETCH;
          end
        end
        default: begin
          r_state <= S_HALT;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_param_core.sv
// Bench for param_core: variable-latency memory models plus a store scoreboard.
// Expected stores are queued when a program is launched and checked as the core writes.
module tb_param_core;
  localparam int DATA_W = 32;
  localparam int NREG   = 16;
  localparam int PC_W   = 6;
  localparam int AR_W   = 12;
  localparam int IW     = 20;

  localparam logic [3:0] NOP = 4'd0,  LDI = 4'd1,  ADD = 4'd2,  SUB = 4'd3;
  localparam logic [3:0] ANDO = 4'd4, ORO = 4'd5,  XORO = 4'd6, SHL = 4'd7;
  localparam logic [3:0] LD  = 4'd8,  ST  = 4'd9,  JMP = 4'd10, JZ  = 4'd11;
  localparam logic [3:0] MOV = 4'd12, HALT = 4'd13, MUL = 4'd14, ILL = 4'd15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic end_o;
  logic err_o;

  param_core_if #(.DATA_W(DATA_W), .NREG(NREG), .PC_W(PC_W), .AR_W(AR_W)) bus ();

  param_core #(.DATA_W(DATA_W), .NREG(NREG), .PC_W(PC_W), .AR_W(AR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .End (end_o),
    .err (err_o)
  );

  always #5 clk = ~clk;

  logic [IW-1:0]     imem [64];
  logic [DATA_W-1:0] dmem [4096];
  int iwait = 0;
  int dwait = 0;
  int icnt  = 0;
  int dcnt  = 0;

  assign bus.imem_ack   = bus.imem_req && (icnt >= iwait);
  assign bus.imem_data  = imem[bus.imem_addr];
  assign bus.dmem_ack   = bus.dmem_req && (dcnt >= dwait);
  assign bus.dmem_rdata = dmem[bus.dmem_addr];

  initial forever begin
    @(posedge clk);
    if (rst) begin
      icnt <= 0;
      dcnt <= 0;
    end else begin
      icnt <= (bus.imem_req && !bus.imem_ack) ? icnt + 1 : 0;
      dcnt <= (bus.dmem_req && !bus.dmem_ack) ? dcnt + 1 : 0;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [AR_W-1:0]   addr;
    logic [DATA_W-1:0] data;
  } st_t;
  st_t sb [$];

  task automatic expect_st(input logic [AR_W-1:0] a, input logic [DATA_W-1:0] d);
    st_t e;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  // Data-side monitor: request stability during stalls, stall length, store scoreboard.
  logic              d_pend = 1'b0;
  int                d_cycles = 0;
  logic [AR_W-1:0]   d_addr;
  logic              d_we;
  logic [DATA_W-1:0] d_wdata;

  initial forever begin
    @(negedge clk);
    if (rst || !bus.dmem_req) begin
      d_pend   = 1'b0;
      d_cycles = 0;
    end else begin
      if (d_pend) begin
        chk("dmem_addr_stable", bus.dmem_addr, d_addr);
        chk("dmem_we_stable", bus.dmem_we, d_we);
        chk("dmem_wdata_stable", bus.dmem_wdata, d_wdata);
      end else begin
        d_addr  = bus.dmem_addr;
        d_we    = bus.dmem_we;
        d_wdata = bus.dmem_wdata;
        d_pend  = 1'b1;
      end
      d_cycles++;
      if (bus.dmem_ack) begin
        chk("dmem_req_cycles", d_cycles, dwait + 1);
        if (bus.dmem_we) begin
          dmem[bus.dmem_addr] = bus.dmem_wdata;
          if (sb.size() == 0) begin
            chk("unexpected_store_addr", bus.dmem_addr, 12'hFFF);
          end else begin
            st_t e;
            e = sb.pop_front();
            chk("store_addr", bus.dmem_addr, e.addr);
            chk("store_data", bus.dmem_wdata, e.data);
          end
        end
        d_pend   = 1'b0;
        d_cycles = 0;
      end
    end
  end

  function automatic logic [IW-1:0] enc_i(input logic [3:0] op, input logic [3:0] rd,
                                          input logic [11:0] imm);
    return {op, rd, imm};
  endfunction

  function automatic logic [IW-1:0] enc_r(input logic [3:0] op, input logic [3:0] rd,
                                          input logic [3:0] ra, input logic [3:0] rb);
    return {op, rd, ra, rb, 4'h0};
  endfunction

  task automatic fill_imem(input logic [IW-1:0] w);
    for (int i = 0; i < 64; i++) imem[i] = w;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_reset_state();
    chk("rst_imem_req", bus.imem_req, 1);
    chk("rst_imem_addr", bus.imem_addr, 0);
    chk("rst_dmem_req", bus.dmem_req, 0);
    chk("rst_dmem_we", bus.dmem_we, 0);
    chk("rst_dmem_addr", bus.dmem_addr, 0);
    chk("rst_dmem_wdata", bus.dmem_wdata, 0);
    chk("rst_end", end_o, 0);
    chk("rst_err", err_o, 0);
  endtask

  task automatic wait_end(input int limit);
    for (int c = 0; c < limit; c++) begin
      if (end_o) break;
      @(negedge clk);
    end
  endtask

  task automatic run_prog(input string name, input logic exp_err, input int limit);
    apply_reset();
    wait_end(limit);
    chk({name, "_end"}, end_o, 1);
    chk({name, "_err"}, err_o, exp_err);
    chk({name, "_pending_stores"}, sb.size(), 0);
    sb.delete();
  endtask

  typedef struct {
    logic [3:0]        op;
    logic [11:0]       a;
    logic [11:0]       b;
    logic [DATA_W-1:0] res;
    logic [DATA_W-1:0] mark;  // 2 = JZ taken (Z set), 1 = not taken
  } vec_t;
  vec_t vecs [$];

  initial begin
    vec_t v;
    int prev;
    logic have_prev;
    logic wrapped;
    logic saw_ld;

    vecs.push_back('{ADD,  12'h005, 12'h003, 32'h0000_0008, 32'd1});
    vecs.push_back('{ADD,  12'h000, 12'h000, 32'h0000_0000, 32'd2});
    vecs.push_back('{SUB,  12'h005, 12'h007, 32'hFFFF_FFFE, 32'd1});
    vecs.push_back('{SUB,  12'h009, 12'h009, 32'h0000_0000, 32'd2});
    vecs.push_back('{ANDO, 12'hF0F, 12'h0FF, 32'h0000_000F, 32'd1});
    vecs.push_back('{ANDO, 12'hF00, 12'h0FF, 32'h0000_0000, 32'd2});
    vecs.push_back('{ORO,  12'hA00, 12'h05A, 32'h0000_0A5A, 32'd1});
    vecs.push_back('{XORO, 12'hFFF, 12'hFFF, 32'h0000_0000, 32'd2});
    vecs.push_back('{XORO, 12'h123, 12'h321, 32'h0000_0202, 32'd1});
    vecs.push_back('{SHL,  12'h800, 12'h000, 32'h0000_1000, 32'd1});
    vecs.push_back('{MOV,  12'h000, 12'h000, 32'h0000_0000, 32'd1});
`ifdef PARAM_CORE_MUL_EN
    vecs.push_back('{MUL,  12'h00C, 12'h00B, 32'h0000_0084, 32'd1});
`endif

    fill_imem({ILL, 16'h0});
    for (int i = 0; i < 4096; i++) dmem[i] = '0;

    // Reset values and basic timing.
    imem[0] = enc_i(LDI, 1, 12'd5);
    imem[1] = enc_i(LDI, 2, 12'd3);
    imem[2] = enc_r(SUB, 3, 1, 2);
    imem[3] = enc_i(HALT, 0, 0);
    apply_reset();
    chk_reset_state();
    repeat (7) @(posedge clk);
    #1 chk("halt_cycle7_end", end_o, 0);
    @(posedge clk);
    #1 chk("halt_cycle8_end", end_o, 1);
    chk("halt_cycle8_err", err_o, 0);
    chk("halt_imem_req", bus.imem_req, 0);

    // Store then load with a three-cycle data stall.
    fill_imem({ILL, 16'h0});
    dmem[12'h030] = 32'hDEADBEEF;
    dmem[12'h00A] = 32'h0;
    imem[0] = enc_i(LDI, 1, 12'h030);
    imem[1] = enc_r(LD, 2, 1, 0);
    imem[2] = enc_i(LDI, 3, 12'h00A);
    imem[3] = enc_r(ST, 2, 3, 0);
    imem[4] = enc_r(LD, 4, 3, 0);
    imem[5] = enc_i(LDI, 5, 12'h00B);
    imem[6] = enc_r(ST, 4, 5, 0);
    imem[7] = enc_i(HALT, 0, 0);
    dwait = 3;
    iwait = 1;
    expect_st(12'h00A, 32'hDEADBEEF);
    expect_st(12'h00B, 32'hDEADBEEF);
    run_prog("stld", 1'b0, 300);
    apply_reset();
    chk_reset_state();

    // Taken JZ skips the write to r4.
    dwait = 0;
    iwait = 0;
    fill_imem({ILL, 16'h0});
    imem[0] = enc_i(LDI, 1, 12'd7);
    imem[1] = enc_r(SUB, 2, 1, 1);
    imem[2] = enc_i(JZ, 0, 12'd5);
    imem[3] = enc_i(LDI, 4, 12'd1);
    imem[4] = enc_i(HALT, 0, 0);
    imem[5] = enc_i(LDI, 5, 12'h040);
    imem[6] = enc_r(ST, 4, 5, 0);
    imem[7] = enc_i(HALT, 0, 0);
    expect_st(12'h040, 32'h0);
    run_prog("jz_taken", 1'b0, 200);

    // Operation table: result stored to 0x20, Z observed through a JZ marker at 0x21.
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      iwait = i % 3;
      dwait = i % 2;
      fill_imem({ILL, 16'h0});
      imem[0]  = enc_i(LDI, 1, v.a);
      imem[1]  = enc_i(LDI, 2, v.b);
      imem[2]  = enc_i(LDI, 5, 12'h020);
      imem[3]  = enc_r(v.op, 3, 1, 2);
      imem[4]  = enc_i(JZ, 0, 12'd7);
      imem[5]  = enc_i(LDI, 6, 12'd1);
      imem[6]  = enc_i(JMP, 0, 12'd8);
      imem[7]  = enc_i(LDI, 6, 12'd2);
      imem[8]  = enc_r(ST, 3, 5, 0);
      imem[9]  = enc_i(LDI, 5, 12'h021);
      imem[10] = enc_r(ST, 6, 5, 0);
      imem[11] = enc_i(HALT, 0, 0);
      expect_st(12'h020, v.res);
      expect_st(12'h021, v.mark);
      run_prog($sformatf("vec%0d_op%0d", i, v.op), 1'b0, 400);
    end

    // Opcode 14 on 0x10000 * 0x10000.
    iwait = 0;
    dwait = 0;
    fill_imem({ILL, 16'h0});
    imem[0] = enc_i(LDI, 1, 12'h010);
    for (int i = 1; i <= 12; i++) imem[i] = enc_r(SHL, 1, 1, 0);
    imem[13] = enc_r(MOV, 2, 1, 0);
    imem[14] = enc_i(LDI, 5, 12'h020);
    imem[15] = enc_r(MUL, 3, 1, 2);
    imem[16] = enc_i(JZ, 0, 12'd19);
    imem[17] = enc_i(LDI, 6, 12'd1);
    imem[18] = enc_i(JMP, 0, 12'd20);
    imem[19] = enc_i(LDI, 6, 12'd2);
    imem[20] = enc_r(ST, 3, 5, 0);
    imem[21] = enc_i(LDI, 5, 12'h021);
    imem[22] = enc_r(ST, 6, 5, 0);
    imem[23] = enc_i(HALT, 0, 0);
`ifdef PARAM_CORE_MUL_EN
    expect_st(12'h020, 32'h0);
    expect_st(12'h021, 32'd2);
    run_prog("mul_wrap", 1'b0, 400);
`else
    run_prog("op14_illegal", 1'b1, 400);
`endif

    // Opcode 15 halts with err; reset from HALT clears both flags.
    fill_imem({ILL, 16'h0});
    imem[0] = enc_i(LDI, 1, 12'd1);
    run_prog("op15_illegal", 1'b1, 100);
    apply_reset();
    chk_reset_state();

    // PC wraps 63 -> 0 over an all-NOP program.
    fill_imem({NOP, 16'h0});
    apply_reset();
    prev = 0;
    have_prev = 1'b0;
    wrapped = 1'b0;
    for (int c = 0; c < 160; c++) begin
      @(negedge clk);
      if (bus.imem_req && bus.imem_ack) begin
        if (have_prev) chk("fetch_seq", bus.imem_addr, (prev + 1) % 64);
        if (prev == 63 && bus.imem_addr == 0) wrapped = 1'b1;
        prev = int'(bus.imem_addr);
        have_prev = 1'b1;
      end
    end
    chk("pc_wrapped", wrapped, 1);
    chk("nop_no_end", end_o, 0);

    // Reset in the middle of a stalled LD.
    fill_imem({ILL, 16'h0});
    dmem[12'h030] = 32'h12345678;
    imem[0] = enc_i(LDI, 1, 12'h030);
    imem[1] = enc_i(LDI, 7, 12'h055);
    imem[2] = enc_r(LD, 7, 1, 0);
    dwait = 10;
    expect_st(12'h040, 32'h0);
    apply_reset();
    saw_ld = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus.dmem_req) begin
        saw_ld = 1'b1;
        break;
      end
    end
    chk("ld_started", saw_ld, 1);
    repeat (2) @(negedge clk);
    imem[0] = enc_i(LDI, 5, 12'h040);
    imem[1] = enc_r(ST, 7, 5, 0);
    imem[2] = enc_i(HALT, 0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midld_dmem_req", bus.dmem_req, 0);
    chk("midld_imem_addr", bus.imem_addr, 0);
    chk("midld_imem_req", bus.imem_req, 1);
    dwait = 0;
    rst = 1'b0;
    wait_end(200);
    chk("midld_end", end_o, 1);
    chk("midld_err", err_o, 0);
    chk("midld_pending_stores", sb.size(), 0);
    sb.delete();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
